// File: rtl/nand_array_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit NAND array among NREQ requesters,
// returning each result through a single registered response slot with backpressure.

module nand2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = ~(a & b);
endmodule

module nand_array_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [15:0]              op_count
);
    localparam int IDW = $clog2(NREQ);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]                   state;
    logic [IDW-1:0]               ptr;
    logic [NREQ-1:0][WIDTH-1:0]   a_arr;
    logic [NREQ-1:0][WIDTH-1:0]   b_arr;
    logic                         found;
    logic [IDW-1:0]               gnt_idx;
    logic                         accept;
    logic                         grant;
    logic [WIDTH-1:0]             mux_a;
    logic [WIDTH-1:0]             mux_b;
    logic [WIDTH-1:0]             nand_y;
    logic [IDW-1:0]               ptr_next;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        int idx;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    // The output slot is free when empty or being drained this cycle.
    assign accept = (state == IDLE) || rsp_ready;
    assign grant  = accept && found && !rst;

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[gnt_idx] = 1'b1;
    end

    assign mux_a = a_arr[gnt_idx];
    assign mux_b = b_arr[gnt_idx];

    nand2 #(.W(WIDTH)) u_nand (
        .a (mux_a),
        .b (mux_b),
        .y (nand_y)
    );

    assign ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (grant) begin
            state    <= HOLD;
            ptr      <= ptr_next;
            rsp_data <= nand_y;
            rsp_id   <= gnt_idx;
        end else if (state == HOLD && rsp_ready) begin
            state    <= IDLE;
        end
    end

    assign rsp_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_count <= '0;
        else if (rsp_valid && rsp_ready && op_count != 16'hFFFF)
            op_count <= op_count + 16'd1;
    end
endmodule

// File: tb/tb_nand_array_arbiter.sv
// Directed bench for nand_array_arbiter: stimulus pushes expected responses into a
// queue, a monitor pops and compares each accepted response.

module tb_nand_array_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] op_count;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } rsp_t;

    rsp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b1;
    logic [7:0] nand_tbl [4];

    nand_array_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d errors before expiry", errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of stimulus; expects to be entered between a rising edge and the next falling edge.
    task automatic step(input logic [3:0] v, input logic rr, input logic [3:0] er,
                        input int eid, input bit push, input int ecnt);
        req_valid = v;
        rsp_ready = rr;
        @(negedge clk);
        chk("req_ready", {28'd0, req_ready}, {28'd0, er});
        if (ecnt >= 0)
            chk("op_count", {16'd0, op_count}, ecnt);
        if (push && er != 4'd0)
            exp_q.push_back('{id: eid[1:0], data: nand_tbl[eid]});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d data %h expected no response", rsp_id, rsp_data);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
                chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
            end
        end
    end

    initial begin
        // Hand-computed ~(A & B) per requester.
        nand_tbl[0] = 8'hCF;  // F0 & 3C = 30
        nand_tbl[1] = 8'hEE;  // 55 & 33 = 11
        nand_tbl[2] = 8'hF5;  // AA & 0F = 0A
        nand_tbl[3] = 8'hF0;  // 0F & FF = 0F
        req_a     = {8'h0F, 8'hAA, 8'h55, 8'hF0};
        req_b     = {8'hFF, 8'h0F, 8'h33, 8'h3C};
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;

        #2;
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single request, one-cycle latency.
        step(4'b0001, 1'b1, 4'b0001, 0, 1'b1, 0);
        chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        step(4'b0000, 1'b1, 4'b0000, 0, 1'b0, -1);
        chk("single_drained", {31'd0, rsp_valid}, 32'd0);

        // Round-robin from a fresh pointer.
        rst = 1'b1;
        #2 rst = 1'b0;
        step(4'b1111, 1'b1, 4'b0001, 0, 1'b1, 0);
        step(4'b1111, 1'b1, 4'b0010, 1, 1'b1, 0);
        step(4'b1111, 1'b1, 4'b0100, 2, 1'b1, 1);
        step(4'b1111, 1'b1, 4'b1000, 3, 1'b1, 2);
        step(4'b1111, 1'b1, 4'b0001, 0, 1'b1, 3);
        step(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 4);

        // Backpressure: ptr is 1, only requester 0 asks, then 1 and 2 wait behind a held result.
        step(4'b0001, 1'b1, 4'b0001, 0, 1'b1, -1);
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'b0110;
            rsp_ready = 1'b0;
            req_a[31:24] = 8'($urandom);
            @(negedge clk);
            chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", {24'd0, rsp_data}, 32'hCF);
            chk("bp_rsp_id", {30'd0, rsp_id}, 32'd0);
            @(posedge clk);
            #1;
        end
        req_a[31:24] = 8'h0F;
        step(4'b0110, 1'b1, 4'b0010, 1, 1'b1, -1);
        step(4'b0110, 1'b1, 4'b0100, 2, 1'b1, -1);
        step(4'b0000, 1'b1, 4'b0000, 0, 1'b0, -1);

        // Wrap and skip: ptr is 3.
        step(4'b1001, 1'b1, 4'b1000, 3, 1'b1, -1);
        step(4'b1001, 1'b1, 4'b0001, 0, 1'b1, -1);
        step(4'b1111, 1'b1, 4'b0010, 1, 1'b1, -1);
        step(4'b0000, 1'b1, 4'b0000, 0, 1'b0, -1);

        // Asynchronous reset while a result is held.
        step(4'b0100, 1'b0, 4'b0100, 2, 1'b0, -1);
        chk("hold_before_rst", {31'd0, rsp_valid}, 32'd1);
        req_valid = 4'b1100;
        rsp_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_op_count", {16'd0, op_count}, 32'd0);
        chk("arst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("arst_req_ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step(4'b1100, 1'b1, 4'b0100, 2, 1'b1, 0);
        step(4'b0000, 1'b1, 4'b0000, 0, 1'b0, -1);
        chk("queue_empty", exp_q.size(), 32'd0);

        // Saturation of the response counter.
        mon_en    = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("op_count_sat", {16'd0, op_count}, 32'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("op_count_sat_hold", {16'd0, op_count}, 32'hFFFF);
        req_valid = 4'b0000;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
